// File: rtl/list_accum_pkg.sv
// Shared definitions for the linked-list accumulator: FSM state encoding and operation modes.
package list_accum_pkg;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_REQ  = 5'b00010,
        S_WAIT = 5'b00100,
        S_ACC  = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

    localparam logic [1:0] MODE_SUM   = 2'b00;
    localparam logic [1:0] MODE_COUNT = 2'b01;
    localparam logic [1:0] MODE_MAX   = 2'b10;
    localparam logic [1:0] MODE_MIN   = 2'b11;

endpackage

// File: rtl/list_accum_alu.sv
// Combinational accumulate step: folds one node value into the running result by mode.
module list_accum_alu
    import list_accum_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [1:0]        mode,
    input  logic              first,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] value,
    output logic [DATA_W-1:0] new_result,
    output logic              carry
);

    logic [DATA_W:0] w_sum;

    always_comb begin
        w_sum      = {1'b0, result} + {1'b0, value};
        new_result = result;
        carry      = 1'b0;
        case (mode)
            MODE_SUM: begin
                new_result = w_sum[DATA_W-1:0];
                carry      = w_sum[DATA_W];
            end
            MODE_COUNT: new_result = result + DATA_W'(1);
            // The first node seeds max/min so the cleared result never wins.
            MODE_MAX:   new_result = (first || (value > result)) ? value : result;
            MODE_MIN:   new_result = (first || (value < result)) ? value : result;
            default:    new_result = result;
        endcase
    end

endmodule

// File: rtl/list_accum_ctrl.sv
// Walks a linked list in memory from head_addr, accumulating node values (sum/count/max/min).
module list_accum_ctrl
    import list_accum_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int MAX_NODES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] head_addr,
    input  logic [1:0]        mode,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rdy,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata_val,
    input  logic [ADDR_W-1:0] mem_rdata_next,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] node_cnt,
    output logic              overflow,
    output logic              error
);

    localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_NODES);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_val;
    logic [ADDR_W-1:0] r_next;
    logic [DATA_W-1:0] r_result;
    logic [ADDR_W-1:0] r_node_cnt;
    logic              r_overflow;
    logic              r_error;
    logic              r_mem_req;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;
    logic [ADDR_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_node_cnt + ADDR_W'(1);

    list_accum_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .mode      (r_mode),
        .first     (r_node_cnt == '0),
        .result    (r_result),
        .value     (r_val),
        .new_result(w_alu_result),
        .carry     (w_alu_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_mode     <= MODE_SUM;
            r_val      <= '0;
            r_next     <= '0;
            r_result   <= '0;
            r_node_cnt <= '0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
            r_mem_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_result   <= '0;
                        r_node_cnt <= '0;
                        r_overflow <= 1'b0;
                        r_error    <= 1'b0;
                        if (head_addr != '0) begin
                            r_ptr     <= head_addr;
                            r_mem_req <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= S_REQ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_rdy) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_val   <= mem_rdata_val;
                        r_next  <= mem_rdata_next;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_result   <= w_alu_result;
                    r_node_cnt <= w_cnt_inc;
                    r_overflow <= r_overflow | w_alu_carry;
                    if (r_next == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_cnt_inc == MAX_CNT) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ptr     <= r_next;
                        r_mem_req <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_ptr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign node_cnt = r_node_cnt;
    assign overflow = r_overflow;
    assign error    = r_error;

endmodule

// File: tb/tb_list_accum_ctrl.sv
// Directed bench for list_accum_ctrl: memory responses are served cycle by cycle from the stimulus thread.
module tb_list_accum_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  head_addr;
    logic [1:0]  mode;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_rdy;
    logic        mem_rvalid;
    logic [15:0] mem_rdata_val;
    logic [7:0]  mem_rdata_next;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  node_cnt;
    logic        overflow;
    logic        error;

    int vectors = 0;
    int errs    = 0;

    logic [15:0] mval  [256];
    logic [7:0]  mnext [256];

    list_accum_ctrl #(
        .DATA_W   (16),
        .ADDR_W   (8),
        .MAX_NODES(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .head_addr     (head_addr),
        .mode          (mode),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdy       (mem_rdy),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata_val (mem_rdata_val),
        .mem_rdata_next(mem_rdata_next),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .node_cnt      (node_cnt),
        .overflow      (overflow),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raises start at a negedge and acts as memory until done is seen (or 200 cycles pass).
    // req_c/done_c are negedge indices counted from the first edge that samples start.
    task automatic run(input logic [7:0] head, input logic [1:0] md, input int stalls,
                       output int req_c, output int done_c, output bit saw_req, output bit addr_ok);
        bit         pend;
        bit         prev_req;
        logic [7:0] pa;
        logic [7:0] prev_addr;
        int         st;
        st = stalls; pend = 0; prev_req = 0; pa = '0; prev_addr = '0;
        req_c = -1; done_c = -1; saw_req = 0; addr_ok = 1;
        head_addr = head; mode = md; start = 1'b1; mem_rdy = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (pend) begin
                mem_rvalid     = 1'b1;
                mem_rdata_val  = mval[pa];
                mem_rdata_next = mnext[pa];
                pend = 0;
            end
            if (done) begin
                done_c = c;
                break;
            end
            mem_rdy = 1'b0;
            if (mem_req) begin
                if (!saw_req) req_c = c;
                saw_req = 1;
                if (prev_req && (mem_addr !== prev_addr)) addr_ok = 0;
                if (st > 0) begin
                    st--;
                end else begin
                    mem_rdy = 1'b1;
                    pend    = 1;
                    pa      = mem_addr;
                end
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
        end
        mem_rdy = 1'b0;
        chk("run_reached_done", done_c >= 0, 1);
    endtask

    // Start stays high in DONE without retriggering; dropping it returns to idle.
    task automatic release_start(input logic [15:0] exp_res);
        repeat (2) @(negedge clk);
        chk("done_hold", done, 1);
        chk("result_hold", result, exp_res);
        chk("no_retrigger", {busy, mem_req}, 0);
        mem_rvalid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("done_clear", done, 0);
        @(negedge clk);
        chk("idle_quiet", {busy, mem_req, done}, 0);
    endtask

    int rc, dc;
    bit sr, ao;

    initial begin
        rst = 1'b1; start = 1'b0; head_addr = '0; mode = 2'b00;
        mem_rdy = 1'b0; mem_rvalid = 1'b0; mem_rdata_val = '0; mem_rdata_next = '0;
        for (int i = 0; i < 256; i++) begin
            mval[i] = '0;
            mnext[i] = '0;
        end
        mval[8'h10] = 16'd5;      mnext[8'h10] = 8'h20;
        mval[8'h20] = 16'd7;      mnext[8'h20] = 8'h30;
        mval[8'h30] = 16'd9;      mnext[8'h30] = 8'h00;
        mval[8'h40] = 16'hFFF0;   mnext[8'h40] = 8'h41;
        mval[8'h41] = 16'h0020;   mnext[8'h41] = 8'h00;
        mval[8'h50] = 16'd1;      mnext[8'h50] = 8'h50;

        repeat (2) @(negedge clk);
        chk("rst_outputs", {mem_req, busy, done, overflow, error}, 0);
        chk("rst_result", result, 0);
        chk("rst_node_cnt", node_cnt, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Sum over 5 -> 7 -> 9, zero-wait memory.
        run(8'h10, 2'b00, 0, rc, dc, sr, ao);
        chk("sum_result", result, 21);
        chk("sum_node_cnt", node_cnt, 3);
        chk("sum_latency", dc - rc, 9);
        chk("sum_first_req", rc, 0);
        chk("sum_flags", {overflow, error, busy}, 0);
        release_start(16'd21);

        // Empty list.
        run(8'h00, 2'b00, 0, rc, dc, sr, ao);
        chk("null_done_next_cycle", dc, 0);
        chk("null_no_req", sr, 0);
        chk("null_result", result, 0);
        chk("null_node_cnt", node_cnt, 0);
        release_start(16'd0);

        run(8'h10, 2'b01, 0, rc, dc, sr, ao);
        chk("count_result", result, 3);
        chk("count_node_cnt", node_cnt, 3);
        release_start(16'd3);

        run(8'h10, 2'b10, 0, rc, dc, sr, ao);
        chk("max_result", result, 9);
        release_start(16'd9);

        run(8'h10, 2'b11, 0, rc, dc, sr, ao);
        chk("min_result", result, 5);
        chk("min_node_cnt", node_cnt, 3);
        release_start(16'd5);

        // 0xFFF0 + 0x0020 wraps.
        run(8'h40, 2'b00, 0, rc, dc, sr, ao);
        chk("wrap_result", result, 16'h0010);
        chk("wrap_overflow", overflow, 1);
        chk("wrap_node_cnt", node_cnt, 2);
        chk("wrap_latency", dc - rc, 6);
        release_start(16'h0010);

        run(8'h10, 2'b00, 0, rc, dc, sr, ao);
        chk("overflow_cleared", overflow, 0);
        chk("sum2_result", result, 21);
        release_start(16'd21);

        // Self-loop trips the node guard; first request stalled 3 cycles.
        run(8'h50, 2'b00, 3, rc, dc, sr, ao);
        chk("loop_error", error, 1);
        chk("loop_node_cnt", node_cnt, 4);
        chk("loop_result", result, 4);
        chk("loop_addr_stable", ao, 1);
        chk("loop_addr", mem_addr, 8'h50);
        chk("loop_stall_latency", dc - rc, 15);
        release_start(16'd4);

        run(8'h10, 2'b01, 0, rc, dc, sr, ao);
        chk("error_cleared", error, 0);
        release_start(16'd3);

        // Reset while waiting for the response, then a late response.
        head_addr = 8'h10; mode = 2'b00; start = 1'b1;
        @(negedge clk);
        chk("mid_req", mem_req, 1);
        mem_rdy = 1'b1;
        @(negedge clk);
        chk("mid_wait", {busy, mem_req}, 2'b10);
        mem_rdy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        mem_rvalid = 1'b1; mem_rdata_val = 16'd5; mem_rdata_next = 8'h20;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("post_rst_outputs", {mem_req, busy, done, overflow, error}, 0);
        chk("post_rst_result", result, 0);
        chk("post_rst_node_cnt", node_cnt, 0);
        repeat (3) @(negedge clk);
        chk("post_rst_still_idle", {mem_req, busy, done}, 0);
        chk("post_rst_addr", mem_addr, 0);

        run(8'h10, 2'b00, 0, rc, dc, sr, ao);
        chk("after_rst_result", result, 21);
        chk("after_rst_node_cnt", node_cnt, 3);
        chk("after_rst_latency", dc - rc, 9);
        release_start(16'd21);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
